// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the ID-stage issue control slice.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    EXC_REQ = 2'd2,
    FLUSH   = 2'd3
  } id_issue_state_e;

  localparam int         EXC_CAUSE_W           = 5;
  localparam logic [4:0] EXC_CAUSE_FETCH_FAULT = 5'd1;
  localparam logic [4:0] EXC_CAUSE_ILLEGAL_C   = 5'd2;

endpackage

// File: rtl/cv32e40p_id_ex_reg.sv
// One-entry ID/EX issue register: clear beats load, load beats drain, else hold.
module cv32e40p_id_ex_reg
  import cv32e40p_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        compressed_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        compressed_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        compressed_q, compressed_d;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    compressed_d = compressed_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d      = 1'b1;
      instr_d      = instr_i;
      pc_d         = pc_i;
      compressed_d = compressed_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      pc_q         <= 32'd0;
      compressed_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      compressed_q <= compressed_d;
    end
  end

  assign valid_o      = valid_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_q;
  assign compressed_o = compressed_q;

endmodule

// File: rtl/cv32e40p_id_issue_ctrl.sv
// ID-stage consumer of the IF/ID handshake: issues into EX and turns faulty
// entries into a held exception request, flushing the entry once acknowledged.
module cv32e40p_id_issue_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int                   CAUSE_W           = EXC_CAUSE_W,
  parameter logic [CAUSE_W-1:0]   FETCH_FAULT_CAUSE = CAUSE_W'(EXC_CAUSE_FETCH_FAULT),
  parameter logic [CAUSE_W-1:0]   ILLEGAL_CAUSE     = CAUSE_W'(EXC_CAUSE_ILLEGAL_C)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid_id_i,
  input  logic [31:0]        instr_rdata_id_i,
  input  logic [31:0]        pc_id_i,
  input  logic               is_compressed_id_i,
  input  logic               illegal_c_insn_id_i,
  input  logic               is_fetch_failed_i,
  input  logic               ex_ready_i,
  input  logic               flush_i,
  input  logic               exc_ack_i,
  output logic               id_ready_o,
  output logic               clear_instr_valid_o,
  output logic               halt_if_o,
  output logic               issue_valid_o,
  output logic [31:0]        issue_instr_o,
  output logic [31:0]        issue_pc_o,
  output logic               issue_compressed_o,
  output logic               exc_req_o,
  output logic [CAUSE_W-1:0] exc_cause_o,
  output logic [31:0]        exc_pc_o
);

  id_issue_state_e    state_q, state_d;
  logic               exc_req_q, exc_req_d;
  logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;
  logic [31:0]        exc_pc_q, exc_pc_d;

  logic free;
  logic exc_trig;
  logic load;
  logic clear_instr_valid;

  assign free     = ~issue_valid_o | ex_ready_i;
  assign exc_trig = is_fetch_failed_i | (instr_valid_id_i & illegal_c_insn_id_i);

  always_comb begin
    state_d           = state_q;
    exc_req_d         = exc_req_q;
    exc_cause_d       = exc_cause_q;
    exc_pc_d          = exc_pc_q;
    load              = 1'b0;
    clear_instr_valid = 1'b0;
    if (flush_i) begin
      state_d           = RUN;
      exc_req_d         = 1'b0;
      clear_instr_valid = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (exc_trig) begin
            // An already-empty issue register skips DRAIN entirely.
            state_d     = issue_valid_o ? DRAIN : EXC_REQ;
            exc_req_d   = ~issue_valid_o;
            exc_cause_d = is_fetch_failed_i ? FETCH_FAULT_CAUSE : ILLEGAL_CAUSE;
            exc_pc_d    = pc_id_i;
          end else if (instr_valid_id_i && free) begin
            load              = 1'b1;
            clear_instr_valid = 1'b1;
          end
        end
        DRAIN: begin
          if (!issue_valid_o) begin
            state_d   = EXC_REQ;
            exc_req_d = 1'b1;
          end
        end
        EXC_REQ: begin
          if (exc_ack_i) begin
            state_d   = FLUSH;
            exc_req_d = 1'b0;
          end
        end
        FLUSH: begin
          clear_instr_valid = 1'b1;
          state_d           = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      exc_req_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      exc_req_q   <= exc_req_d;
      exc_cause_q <= exc_cause_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  cv32e40p_id_ex_reg u_id_ex_reg (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .drain_i      (ex_ready_i),
    .clear_i      (flush_i),
    .instr_i      (instr_rdata_id_i),
    .pc_i         (pc_id_i),
    .compressed_i (is_compressed_id_i),
    .valid_o      (issue_valid_o),
    .instr_o      (issue_instr_o),
    .pc_o         (issue_pc_o),
    .compressed_o (issue_compressed_o)
  );

  assign id_ready_o          = (state_q == RUN) & free & ~flush_i;
  assign halt_if_o           = (state_q != RUN);
  assign clear_instr_valid_o = clear_instr_valid;
  assign exc_req_o           = exc_req_q;
  assign exc_cause_o         = exc_cause_q;
  assign exc_pc_o            = exc_pc_q;

endmodule

// File: tb/tb_cv32e40p_id_issue_ctrl.sv
// Directed bench for cv32e40p_id_issue_ctrl: streaming, stall, exceptions, flush, reset.
module tb_cv32e40p_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        cmp;
  logic        ill;
  logic        ff;
  logic        exr;
  logic        fl;
  logic        ack;

  logic        id_ready, clr, halt, ivld, icmp, ereq;
  logic [31:0] iinstr, ipc, epc;
  logic [4:0]  ecause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cv32e40p_id_issue_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_valid_id_i    (iv),
    .instr_rdata_id_i    (instr),
    .pc_id_i             (pc),
    .is_compressed_id_i  (cmp),
    .illegal_c_insn_id_i (ill),
    .is_fetch_failed_i   (ff),
    .ex_ready_i          (exr),
    .flush_i             (fl),
    .exc_ack_i           (ack),
    .id_ready_o          (id_ready),
    .clear_instr_valid_o (clr),
    .halt_if_o           (halt),
    .issue_valid_o       (ivld),
    .issue_instr_o       (iinstr),
    .issue_pc_o          (ipc),
    .issue_compressed_o  (icmp),
    .exc_req_o           (ereq),
    .exc_cause_o         (ecause),
    .exc_pc_o            (epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc    = p;
    instr = 32'hA000_0000 | p;
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; cmp = 1'b0; ill = 1'b0; ff = 1'b0;
    exr = 1'b0; fl = 1'b0; ack = 1'b0; set_pc(32'h0);
    cyc(); cyc();
    chk("rst_ivld", {31'd0, ivld}, 32'd0);
    chk("rst_ereq", {31'd0, ereq}, 32'd0);
    chk("rst_cause", {27'd0, ecause}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_ipc", ipc, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    rst = 1'b0;
    #1 chk("rst_idready", {31'd0, id_ready}, 32'd1);

    // Four-instruction stream at full throughput
    iv = 1'b1; exr = 1'b1; set_pc(32'h80);
    #1 chk("s0_clr", {31'd0, clr}, 32'd1);
    chk("s0_idready", {31'd0, id_ready}, 32'd1);
    cyc();
    chk("s1_vld", {31'd0, ivld}, 32'd1);
    chk("s1_pc", ipc, 32'h80);
    set_pc(32'h84);
    #1 chk("s1_clr", {31'd0, clr}, 32'd1);
    cyc();
    chk("s2_pc", ipc, 32'h84);
    set_pc(32'h88); cmp = 1'b1;
    cyc();
    chk("s3_pc", ipc, 32'h88);
    chk("s3_cmp", {31'd0, icmp}, 32'd1);
    set_pc(32'h8C); cmp = 1'b0;
    cyc();
    chk("s4_pc", ipc, 32'h8C);
    chk("s4_vld", {31'd0, ivld}, 32'd1);
    iv = 1'b0;
    cyc();
    chk("s5_vld", {31'd0, ivld}, 32'd0);

    // EX stall with IF/ID waiting
    iv = 1'b1; set_pc(32'h90);
    cyc();
    chk("st_pc0", ipc, 32'h90);
    exr = 1'b0; set_pc(32'h94);
    #1 chk("st_idready", {31'd0, id_ready}, 32'd0);
    chk("st_clr", {31'd0, clr}, 32'd0);
    cyc();
    chk("st_hold1", iinstr, 32'hA000_0090);
    cyc();
    chk("st_hold2", iinstr, 32'hA000_0090);
    chk("st_vld", {31'd0, ivld}, 32'd1);
    exr = 1'b1;
    #1 chk("st_rel_idready", {31'd0, id_ready}, 32'd1);
    chk("st_rel_clr", {31'd0, clr}, 32'd1);
    cyc();
    chk("st_next_pc", ipc, 32'h94);
    iv = 1'b0;
    cyc();
    chk("st_empty", {31'd0, ivld}, 32'd0);

    // Fetch fault with full issue register and EX stalled
    iv = 1'b1; set_pc(32'hF0);
    cyc();
    iv = 1'b0; ff = 1'b1; exr = 1'b0; set_pc(32'h100);
    #1 chk("ff_clr", {31'd0, clr}, 32'd0);
    cyc();
    chk("ff_halt0", {31'd0, halt}, 32'd1);
    chk("ff_vld0", {31'd0, ivld}, 32'd1);
    chk("ff_idready", {31'd0, id_ready}, 32'd0);
    cyc();
    chk("ff_halt1", {31'd0, halt}, 32'd1);
    chk("ff_ereq1", {31'd0, ereq}, 32'd0);
    exr = 1'b1;
    cyc();
    chk("ff_drained", {31'd0, ivld}, 32'd0);
    chk("ff_ereq2", {31'd0, ereq}, 32'd0);
    chk("ff_halt2", {31'd0, halt}, 32'd1);
    cyc();
    chk("ff_ereq3", {31'd0, ereq}, 32'd1);
    chk("ff_cause", {27'd0, ecause}, 32'd1);
    chk("ff_epc", epc, 32'h100);
    cyc();
    chk("ff_ereq_hold", {31'd0, ereq}, 32'd1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    #1 chk("ff_flush_clr", {31'd0, clr}, 32'd1);
    chk("ff_flush_halt", {31'd0, halt}, 32'd1);
    chk("ff_flush_ereq", {31'd0, ereq}, 32'd0);
    ff = 1'b0;
    cyc();
    chk("ff_run_halt", {31'd0, halt}, 32'd0);

    // Illegal compressed, issue register empty, ack on first request cycle
    iv = 1'b1; ill = 1'b1; set_pc(32'h200);
    #1 chk("il_clr", {31'd0, clr}, 32'd0);
    cyc();
    chk("il_ereq", {31'd0, ereq}, 32'd1);
    chk("il_cause", {27'd0, ecause}, 32'd2);
    chk("il_epc", epc, 32'h200);
    chk("il_vld", {31'd0, ivld}, 32'd0);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    #1 chk("il_flush_clr", {31'd0, clr}, 32'd1);
    chk("il_flush_vld", {31'd0, ivld}, 32'd0);
    iv = 1'b0; ill = 1'b0;
    cyc();
    chk("il_run_halt", {31'd0, halt}, 32'd0);
    chk("il_never_issued", {31'd0, ivld}, 32'd0);

    // Flush during EXC_REQ without ack, then flush over a normal issue
    ff = 1'b1; set_pc(32'h300);
    cyc();
    chk("fl_ereq", {31'd0, ereq}, 32'd1);
    fl = 1'b1;
    #1 chk("fl_clr", {31'd0, clr}, 32'd1);
    chk("fl_idready", {31'd0, id_ready}, 32'd0);
    cyc();
    chk("fl_ereq0", {31'd0, ereq}, 32'd0);
    chk("fl_halt0", {31'd0, halt}, 32'd0);
    chk("fl_vld0", {31'd0, ivld}, 32'd0);
    ff = 1'b0; iv = 1'b1; set_pc(32'h400);
    cyc();
    chk("fl_noissue", {31'd0, ivld}, 32'd0);
    fl = 1'b0;

    // Reset in the middle of DRAIN
    set_pc(32'h500);
    cyc();
    chk("rd_fill", ipc, 32'h500);
    iv = 1'b0; ff = 1'b1; exr = 1'b0; set_pc(32'h504);
    cyc();
    chk("rd_halt", {31'd0, halt}, 32'd1);
    rst = 1'b1; ff = 1'b0;
    cyc();
    rst = 1'b0;
    chk("rd_halt0", {31'd0, halt}, 32'd0);
    chk("rd_vld0", {31'd0, ivld}, 32'd0);
    chk("rd_cause0", {27'd0, ecause}, 32'd0);
    chk("rd_epc0", epc, 32'd0);
    chk("rd_ipc0", ipc, 32'd0);
    chk("rd_ereq0", {31'd0, ereq}, 32'd0);
    iv = 1'b1; exr = 1'b1; set_pc(32'h600);
    #1 chk("rd_clr", {31'd0, clr}, 32'd1);
    cyc();
    chk("rd_issue_vld", {31'd0, ivld}, 32'd1);
    chk("rd_issue_pc", ipc, 32'h600);
    iv = 1'b0;
    cyc();
    chk("rd_empty", {31'd0, ivld}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_id_issue_ctrl.md
Name: cv32e40p_id_issue_ctrl

Overview:
- Consumer end of the IF/ID pipeline handshake. Reads the IF/ID register outputs and drives back id_ready, clear_instr_valid and halt_if to the IF stage.
- Owns a one-entry ID/EX issue register feeding EX.
- Intercepts fetch-failed and illegal-compressed instructions, halts IF, drains EX, raises an exception request to the controller and flushes the IF/ID entry once the request is acknowledged.

Parameters:
- CAUSE_W, 5, width of exception cause field
- FETCH_FAULT_CAUSE, 5'd1, cause reported for is_fetch_failed
- ILLEGAL_CAUSE, 5'd2, cause reported for illegal compressed instruction

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid_id_i  in  1  IF/ID entry valid
- instr_rdata_id_i  in  32  decompressed instruction in IF/ID
- pc_id_i  in  32  PC of IF/ID entry
- is_compressed_id_i  in  1  entry was compressed
- illegal_c_insn_id_i  in  1  entry is an illegal compressed instruction
- is_fetch_failed_i  in  1  IF/ID holds a failed fetch; meaningful even when instr_valid_id_i=0
- ex_ready_i  in  1  EX accepts issue register contents this cycle
- flush_i  in  1  controller flush (branch/jump/debug), highest non-reset priority
- exc_ack_i  in  1  controller accepts the exception request
- id_ready_o  out  1  ID can accept a new IF/ID entry
- clear_instr_valid_o  out  1  IF/ID entry consumed or flushed
- halt_if_o  out  1  stop IF from advancing
- issue_valid_o  out  1  issue register valid
- issue_instr_o  out  32  issued instruction
- issue_pc_o  out  32  issued PC
- issue_compressed_o  out  1  issued instruction was compressed
- exc_req_o  out  1  exception request, held until acknowledged
- exc_cause_o  out  CAUSE_W  exception cause
- exc_pc_o  out  32  faulting PC

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=RUN.
  - All registered outputs are 0: issue_*, exc_req_o, exc_cause_o, exc_pc_o.
  - Reset mid-exception abandons the request with no ack required.
- Combinational outputs:
  - free = ~issue_valid_o | ex_ready_i.
  - id_ready_o = (state==RUN) & free & ~flush_i.
  - halt_if_o = (state!=RUN).
- RUN state, exception trigger:
  - Condition: is_fetch_failed_i, or (instr_valid_id_i & illegal_c_insn_id_i).
  - Action: go to DRAIN; latch exc_pc_o=pc_id_i and the cause.
  - Fetch failure has priority over illegal.
  - Nothing is issued and clear_instr_valid_o=0.
- RUN state, normal issue:
  - Condition: instr_valid_id_i & free, with no exception trigger.
  - Load the issue register with instr/pc/compressed; issue_valid_o=1 next cycle.
  - clear_instr_valid_o=1 in the same cycle (single-cycle consume).
- RUN state, otherwise: if ex_ready_i, issue_valid_o<=0.
- DRAIN state:
  - IF is halted and nothing new is issued.
  - issue_valid_o clears when ex_ready_i=1.
  - Move to EXC_REQ in the cycle after the issue register is empty; 0 cycles in DRAIN if already empty.
- EXC_REQ state:
  - exc_req_o=1; exc_cause_o and exc_pc_o are stable.
  - On exc_ack_i: exc_req_o<=0, go to FLUSH.
  - An ack in the same cycle exc_req_o rises counts.
- FLUSH state (one cycle):
  - clear_instr_valid_o=1 and halt_if_o=1, then RUN.
- flush_i, in any state, at the next edge:
  - issue_valid_o<=0, exc_req_o<=0, state<=RUN.
  - clear_instr_valid_o=1 in the same cycle.
  - Overrides issue, exception entry and exc_ack_i.
- Throughput: one instruction per cycle sustained while ex_ready_i=1.
- Simultaneous issue and drain (issue register full, ex_ready_i=1, new entry valid) is legal and gives back-to-back issue.
- Issue register data is held while issue_valid_o=1 and ex_ready_i=0.
- Each instruction is issued exactly once; no duplication, no loss.

Decomposition:
- cv32e40p_pkg gets:
  - id_issue_state_e enum {RUN, DRAIN, EXC_REQ, FLUSH}.
  - The EXC_CAUSE_FETCH_FAULT and EXC_CAUSE_ILLEGAL_C constants, used as the parameter defaults.
- One sub-module, cv32e40p_id_ex_reg: the valid/data issue register with load/hold/clear control.
- The FSM stays in the top module.

Test Plan:
- Stream 4 valid instructions (PC 0x80, 0x84, 0x88, 0x8C) with ex_ready_i=1 -> issue_valid_o high for 4 consecutive cycles with matching PCs; clear_instr_valid_o=1 on each accept cycle.
- ex_ready_i=0 for 3 cycles with issue register full and IF/ID valid -> id_ready_o=0 and issue_instr_o stable; on ex_ready_i=1 the next instruction issues the following cycle.
- is_fetch_failed_i=1 at PC 0x100 with issue register full and ex_ready_i=0 for 2 cycles:
  - halt_if_o=1 throughout.
  - exc_req_o rises the cycle after the issue register drains, with exc_cause_o=1 and exc_pc_o=0x100.
  - exc_ack_i 2 cycles later -> one FLUSH cycle with clear_instr_valid_o=1, then halt_if_o=0.
- Illegal compressed instruction at PC 0x200 with fetch_failed=0 -> exc_cause_o=2, exc_pc_o=0x200; never appears on issue_valid_o.
- flush_i pulsed during EXC_REQ with no ack -> next cycle exc_req_o=0, issue_valid_o=0, state RUN, halt_if_o=0.
- rst asserted mid-DRAIN -> next cycle all outputs 0 and halt_if_o=0; the following valid instruction issues normally.
